prio_encoder_arb: RTL and testbench
===================================

Name: prio_encoder_arb

Overview:
Parametrised, registered successor to the 8:3 combinational priority encoder. Captures N request lines into a sticky pending register and selects one index per cycle, in fixed-priority mode (highest index wins) or round-robin mode. Presents the selected index through a one-entry valid/ready output slot, so requests are never lost under backpressure. Sits between request sources (interrupt/event lines) and a single downstream consumer.

Parameters:
N, 8, number of request lines (>=2)
RR, 0, 0 = fixed priority (index N-1 highest), 1 = round-robin
W, $clog2(N), index width (localparam, derived, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_i  input  N  request pulses/levels; a high bit in any cycle registers one request
out_ready  input  1  consumer accepts the slot this cycle
out_valid  output  1  slot holds a selected index
out_idx  output  W  selected request index
out_onehot  output  N  one-hot of out_idx; 0 when out_valid=0
pending  output  N  requests registered but not yet loaded into the slot
busy  output  1  out_valid | (|pending)

Behaviour:
- Reset (async assert, sync deassert internally): out_valid=0, out_idx=0, out_onehot=0, pending=0, RR pointer last=0. All outputs are 0 while rst=1. Requests held in pending at reset are discarded.
- cand = pending | req_i (this cycle's requests are eligible immediately).
- load = (~out_valid | out_ready) & (|cand). On load, the slot registers the picked index and out_valid=1. Otherwise, if out_valid & out_ready, out_valid goes to 0.
- Latency: request at edge t appears as out_valid/out_idx after edge t+1 when the slot is free. Throughput is one index per cycle.
- pending_next = (pending | req_i) & ~(load ? onehot(pick) : 0).
- A request on the bit that is loading this cycle merges into that single load.
- A request on the bit currently held (not loading) sets pending, i.e. it counts as a new request.
- While out_valid=1 and out_ready=0: out_idx and out_onehot are stable, and pending keeps accumulating.
- Fixed mode (RR=0): pick = highest set index of cand, matching the legacy encoder ordering.
- RR mode (RR=1): search descends from last-1, wrapping N-1 down to last. last updates to pick on each load. last=0 after reset, so the first search starts at N-1 and behaves as fixed priority.
- No candidate: no load. out_idx holds its previous value when valid, and is 0 after a consume with nothing to load. Outputs are never X; there is no "default x" behaviour.
- N not a power of two: indices >= N are never produced. RR wrap uses modulo N, not 2^W.

Decomposition:
- Package prio_enc_pkg: MODE_FIXED=0, MODE_RR=1, and an onehot-from-index function.
- Sub-module prio_pick (combinational, parameter N): input vector and start index, outputs found and index of the highest set bit at or below start with wraparound. Fixed mode ties start to N-1.
- Top holds the pending, slot and pointer registers.

Test Plan:
1. RR=0, N=8, ready=1, req=0x08 for one cycle -> next cycle valid=1, idx=3, onehot=0x08; the cycle after, valid=0 and busy=0.
2. RR=0, req=0xA5 pulsed once, ready=1 -> idx 7,5,2,0 on four consecutive cycles; pending 0x25, 0x05, 0x01, 0x00; then valid=0.
3. RR=0, ready=0, req=0x03 pulse -> idx=1 held stable for 5 cycles, pending=0x01; raise ready -> idx=0 the next cycle, then valid=0.
4. RR=0 vs RR=1, req=0xFF held, ready=1 -> fixed mode gives idx=7 every cycle; RR mode gives idx 7,6,5,4,3,2,1,0,7.
5. RR=1, pending=0x0F with valid=1, assert rst mid-cycle -> valid, pending, busy and onehot go to 0 immediately (no clock edge needed); after release, req=0x11 -> idx 4 then 0.
6. N=5 (W=3), RR=1, req=0x1F held -> idx 4,3,2,1,0,4; never 5..7; out_idx is never X with req=0 from reset.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the registered priority encoder / arbiter.
//   MODE_FIXED, MODE_RR : values for the RR parameter of prio_encoder_arb
//   MAX_N, MAX_W        : largest supported request count and its index width
//   onehot_of()         : one-hot vector (MAX_N wide) from an index
package prio_enc_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  localparam int unsigned MAX_N = 64;
  localparam int unsigned MAX_W = 6;

  // One-hot decode; callers truncate the result to their own width.
  function automatic logic [MAX_N-1:0] onehot_of(input logic [MAX_W-1:0] idx);
    logic [MAX_N-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/prio_encoder_arb_pick.sv
// Combinational wrap-around priority search.
// Finds the highest set bit of vec at or below start; if none, continues from
// N-1 downward to start+1. Only indices 0..N-1 are ever visited, so the wrap
// is modulo N even when N is not a power of two.
//   vec   : candidate vector (N bits)
//   start : first index examined (must be < N)
//   found : any bit of vec set
//   idx   : selected index (0 when found=0)
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         vec,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned W = $clog2(N);

  // Walk downward from start, first hit wins.
  always_comb begin
    logic [W-1:0] pos;
    found = 1'b0;
    idx   = '0;
    pos   = start;
    for (int k = 0; k < int'(N); k++) begin
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
      pos = (pos == '0) ? W'(N - 1) : pos - W'(1);
    end
  end

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter with a one-entry valid/ready slot.
// Requests are captured into a sticky pending register; each cycle the slot
// (when free or being consumed) loads one index picked from pending|req,
// either by fixed priority (highest index) or round-robin.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset (deassertion synchronised)
//   req_i      : request lines; a high bit in any cycle registers one request
//   out_ready  : consumer accepts the slot this cycle
//   out_valid  : slot holds a selected index
//   out_idx    : selected request index
//   out_onehot : one-hot of out_idx, 0 when out_valid=0
//   pending    : requests registered but not yet loaded into the slot
//   busy       : out_valid | (|pending)
module prio_encoder_arb
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned RR = MODE_FIXED,
  localparam int unsigned W  = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [N-1:0] pending,
  output logic         busy
);

  // Reset: asserts immediately, releases two clocks after rst falls.
  logic [1:0] rst_sync;
  logic       rst_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_int = rst_sync[1];

  logic [W-1:0] last;

  logic [N-1:0] cand;
  logic [W-1:0] start;
  logic         found;
  logic [W-1:0] pick;
  logic [N-1:0] pick_oh;
  logic         load;
  logic         consume;

  logic         valid_n;
  logic [W-1:0] idx_n;
  logic [N-1:0] onehot_n;
  logic [N-1:0] pending_n;
  logic         busy_n;
  logic [W-1:0] last_n;

  // This cycle's requests are eligible immediately.
  assign cand = pending | req_i;

  // Round-robin resumes just below the last grant; last=0 starts at N-1.
  always_comb begin
    start = W'(N - 1);
    if (RR == MODE_RR) begin
      start = (last == '0) ? W'(N - 1) : last - W'(1);
    end
  end

  prio_pick #(
    .N (N)
  ) u_pick (
    .vec   (cand),
    .start (start),
    .found (found),
    .idx   (pick)
  );

  assign pick_oh = N'(onehot_of(MAX_W'(pick)));
  assign consume = out_valid & out_ready;
  assign load    = (~out_valid | out_ready) & found;

  // Slot, pending and pointer next-state.
  always_comb begin
    valid_n  = out_valid;
    idx_n    = out_idx;
    onehot_n = out_onehot;
    last_n   = last;
    if (load) begin
      valid_n  = 1'b1;
      idx_n    = pick;
      onehot_n = pick_oh;
      last_n   = pick;
    end else if (consume) begin
      valid_n  = 1'b0;
      idx_n    = '0;
      onehot_n = '0;
    end
    // A request on the loading bit merges into the load; a request on the
    // held (non-loading) bit stays pending as a fresh request.
    pending_n = cand & ~(load ? pick_oh : '0);
    busy_n    = valid_n | (|pending_n);
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      pending    <= '0;
      busy       <= 1'b0;
      last       <= '0;
    end else begin
      out_valid  <= valid_n;
      out_idx    <= idx_n;
      out_onehot <= onehot_n;
      pending    <= pending_n;
      busy       <= busy_n;
      last       <= last_n;
    end
  end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Self-checking bench for prio_encoder_arb.
// Three instances: N=8 fixed (d0), N=8 round-robin (d1), N=5 round-robin (d2).
// Each table row drives one DUT for one clock and states the slot contents
// expected after that edge; expectations go through a scoreboard queue.
module tb_prio_encoder_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] req0, req1;
  logic [4:0] req2;
  logic       rdy0, rdy1, rdy2;

  logic       v0, v1, v2;
  logic [2:0] i0, i1, i2;
  logic [7:0] oh0, oh1, p0, p1;
  logic [4:0] oh2, p2;
  logic       b0, b1, b2;

  prio_encoder_arb #(.N(8), .RR(0)) d0 (
    .clk(clk), .rst(rst), .req_i(req0), .out_ready(rdy0), .out_valid(v0),
    .out_idx(i0), .out_onehot(oh0), .pending(p0), .busy(b0));

  prio_encoder_arb #(.N(8), .RR(1)) d1 (
    .clk(clk), .rst(rst), .req_i(req1), .out_ready(rdy1), .out_valid(v1),
    .out_idx(i1), .out_onehot(oh1), .pending(p1), .busy(b1));

  prio_encoder_arb #(.N(5), .RR(1)) d2 (
    .clk(clk), .rst(rst), .req_i(req2), .out_ready(rdy2), .out_valid(v2),
    .out_idx(i2), .out_onehot(oh2), .pending(p2), .busy(b2));

  int sel;
  logic       cur_valid, cur_busy;
  logic [2:0] cur_idx;
  logic [7:0] cur_oh, cur_pend;

  always_comb begin
    cur_valid = v0; cur_idx = i0; cur_oh = oh0; cur_pend = p0; cur_busy = b0;
    if (sel == 1) begin
      cur_valid = v1; cur_idx = i1; cur_oh = oh1; cur_pend = p1; cur_busy = b1;
    end else if (sel == 2) begin
      cur_valid = v2; cur_idx = i2; cur_oh = {3'b000, oh2};
      cur_pend = {3'b000, p2}; cur_busy = b2;
    end
  end

  typedef struct {
    int         d;
    logic [7:0] r;
    logic       rd;
    logic       ev;
    logic [2:0] ei;
    logic [7:0] ep;
    logic       eb;
  } vec_t;

  typedef struct {
    logic       ev;
    logic [2:0] ei;
    logic [7:0] eoh;
    logic [7:0] ep;
    logic       eb;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(int d, logic [7:0] r, logic rd, logic ev,
                              logic [2:0] ei, logic [7:0] ep, logic eb);
    vec_t v;
    v.d = d; v.r = r; v.rd = rd; v.ev = ev; v.ei = ei; v.ep = ep; v.eb = eb;
    vecs.push_back(v);
  endfunction

  task automatic check(input string tag, input string what,
                       input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s %s: got %0h want %0h", tag, what, got, want);
    end
  endtask

  task automatic check_slot(input string tag, input exp_t e);
    check(tag, "valid",  8'(cur_valid), 8'(e.ev));
    check(tag, "idx",    8'(cur_idx),   8'(e.ei));
    check(tag, "onehot", cur_oh,        e.eoh);
    check(tag, "pending", cur_pend,     e.ep);
    check(tag, "busy",   8'(cur_busy),  8'(e.eb));
  endtask

  // Drive one DUT for one clock, then compare against the queued expectation.
  task automatic step(input int d, input logic [7:0] r, input logic rd,
                      input logic ev, input logic [2:0] ei, input logic [7:0] ep,
                      input logic eb, input string tag);
    exp_t e;
    logic [7:0] one;
    one = 8'h01;
    case (d)
      0:       begin req0 = r;      rdy0 = rd; end
      1:       begin req1 = r;      rdy1 = rd; end
      default: begin req2 = r[4:0]; rdy2 = rd; end
    endcase
    sel   = d;
    e.ev  = ev;
    e.ei  = ei;
    e.eoh = ev ? (one << ei) : 8'h00;
    e.ep  = ep;
    e.eb  = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    case (d)
      0:       req0 = '0;
      1:       req1 = '0;
      default: req2 = '0;
    endcase
    e = sb.pop_front();
    check_slot(tag, e);
  endtask

  initial begin
    exp_t z;
    z = '{ev: 1'b0, ei: 3'd0, eoh: 8'h00, ep: 8'h00, eb: 1'b0};
    rst = 1'b1;
    req0 = '0; req1 = '0; req2 = '0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    sel = 0;

    // Idle rows cover the synchronised reset release and X-free outputs.
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    add(1, 8'h00, 1, 0, 0, 8'h00, 0);
    add(2, 8'h00, 1, 0, 0, 8'h00, 0);
    // Single request, one-cycle latency, then idle.
    add(0, 8'h08, 1, 1, 3, 8'h00, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    // Fixed priority burst 0xA5.
    add(0, 8'hA5, 1, 1, 7, 8'h25, 1);
    add(0, 8'h00, 1, 1, 5, 8'h05, 1);
    add(0, 8'h00, 1, 1, 2, 8'h01, 1);
    add(0, 8'h00, 1, 1, 0, 8'h00, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    // Backpressure holds the slot while pending stays.
    add(0, 8'h03, 0, 1, 1, 8'h01, 1);
    for (int k = 0; k < 4; k++) add(0, 8'h00, 0, 1, 1, 8'h01, 1);
    add(0, 8'h00, 1, 1, 0, 8'h00, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    // Re-request of held bit becomes pending; request on loading bit merges.
    add(0, 8'h40, 0, 1, 6, 8'h00, 1);
    add(0, 8'h40, 0, 1, 6, 8'h40, 1);
    add(0, 8'h40, 1, 1, 6, 8'h00, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    // Fixed mode with all requests held, then drain.
    for (int k = 0; k < 4; k++) add(0, 8'hFF, 1, 1, 7, 8'h7F, 1);
    add(0, 8'h00, 1, 1, 6, 8'h3F, 1);
    add(0, 8'h00, 1, 1, 5, 8'h1F, 1);
    add(0, 8'h00, 1, 1, 4, 8'h0F, 1);
    add(0, 8'h00, 1, 1, 3, 8'h07, 1);
    add(0, 8'h00, 1, 1, 2, 8'h03, 1);
    add(0, 8'h00, 1, 1, 1, 8'h01, 1);
    add(0, 8'h00, 1, 1, 0, 8'h00, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0);
    // Round-robin with all requests held, then drain.
    add(1, 8'hFF, 1, 1, 7, 8'h7F, 1);
    add(1, 8'hFF, 1, 1, 6, 8'hBF, 1);
    add(1, 8'hFF, 1, 1, 5, 8'hDF, 1);
    add(1, 8'hFF, 1, 1, 4, 8'hEF, 1);
    add(1, 8'hFF, 1, 1, 3, 8'hF7, 1);
    add(1, 8'hFF, 1, 1, 2, 8'hFB, 1);
    add(1, 8'hFF, 1, 1, 1, 8'hFD, 1);
    add(1, 8'hFF, 1, 1, 0, 8'hFE, 1);
    add(1, 8'hFF, 1, 1, 7, 8'h7F, 1);
    add(1, 8'h00, 1, 1, 6, 8'h3F, 1);
    add(1, 8'h00, 1, 1, 5, 8'h1F, 1);
    add(1, 8'h00, 1, 1, 4, 8'h0F, 1);
    add(1, 8'h00, 1, 1, 3, 8'h07, 1);
    add(1, 8'h00, 1, 1, 2, 8'h03, 1);
    add(1, 8'h00, 1, 1, 1, 8'h01, 1);
    add(1, 8'h00, 1, 1, 0, 8'h00, 1);
    add(1, 8'h00, 1, 0, 0, 8'h00, 0);
    // N=5 round-robin: wrap modulo 5, never 5..7.
    add(2, 8'h1F, 1, 1, 4, 8'h0F, 1);
    add(2, 8'h1F, 1, 1, 3, 8'h17, 1);
    add(2, 8'h1F, 1, 1, 2, 8'h1B, 1);
    add(2, 8'h1F, 1, 1, 1, 8'h1D, 1);
    add(2, 8'h1F, 1, 1, 0, 8'h1E, 1);
    add(2, 8'h1F, 1, 1, 4, 8'h0F, 1);
    add(2, 8'h00, 1, 1, 3, 8'h07, 1);
    add(2, 8'h00, 1, 1, 2, 8'h03, 1);
    add(2, 8'h00, 1, 1, 1, 8'h01, 1);
    add(2, 8'h00, 1, 1, 0, 8'h00, 1);
    add(2, 8'h00, 1, 0, 0, 8'h00, 0);

    // Reset state of every instance.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #0;
      check_slot($sformatf("reset_d%0d", d), z);
    end
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].d, vecs[i].r, vecs[i].rd, vecs[i].ev, vecs[i].ei,
           vecs[i].ep, vecs[i].eb, $sformatf("row%0d", i));
    end

    // Asynchronous reset mid-cycle with a held slot and pending requests.
    step(1, 8'h1F, 0, 1, 4, 8'h0F, 1, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    sel = 1;
    check_slot("async_rst", z);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 8'h00, 1, 0, 0, 8'h00, 0, "rel0");
    step(1, 8'h00, 1, 0, 0, 8'h00, 0, "rel1");
    step(1, 8'h00, 1, 0, 0, 8'h00, 0, "rel2");
    step(1, 8'h11, 1, 1, 4, 8'h01, 1, "post_rst0");
    step(1, 8'h00, 1, 1, 0, 8'h00, 1, "post_rst1");
    step(1, 8'h00, 1, 0, 0, 8'h00, 0, "post_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
